// File: rtl/yarvi_scoreboard_if.sv
// Issue/writeback bundle between the decode stage and the register scoreboard.
interface yarvi_scoreboard_if;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NREG      = 32;
    localparam int unsigned CNT_W     = 4;

    logic                 issue_valid;
    logic                 issue_use_rs1;
    logic                 issue_use_rs2;
    logic [REG_IDX_W-1:0] issue_rs1;
    logic [REG_IDX_W-1:0] issue_rs2;
    logic [REG_IDX_W-1:0] issue_rd;
    logic                 issue_long;
    logic                 issue_ready;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [NREG-1:0]      pending;
    logic [CNT_W-1:0]     outstanding;
    logic                 error;

    modport master (
        output issue_valid, issue_use_rs1, issue_use_rs2, issue_rs1, issue_rs2,
               issue_rd, issue_long, wb_valid, wb_rd,
        input  issue_ready, pending, outstanding, error
    );

    modport slave (
        input  issue_valid, issue_use_rs1, issue_use_rs2, issue_rs1, issue_rs2,
               issue_rd, issue_long, wb_valid, wb_rd,
        output issue_ready, pending, outstanding, error
    );
endinterface

// File: rtl/yarvi_scoreboard.sv
// Register scoreboard: tracks destinations of in-flight long-latency ops and
// holds issue on RAW/WAW hazards against them or when too many are in flight.
module yarvi_scoreboard #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic               clock,
    input  logic               reset,
    yarvi_scoreboard_if.slave  sb
);
    localparam int unsigned NREG  = 32;
    localparam int unsigned CNT_W = 4;

    logic [NREG-1:0]  pending_q;
    logic [NREG-1:0]  pending_d;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    logic             error_q;
    logic             error_d;

    logic [NREG-1:0]  wbclr_c;
    logic [NREG-1:0]  epend_c;
    logic [NREG-1:0]  set_c;
    logic             full_c;
    logic             ready_c;
    logic             fire_c;
    logic             inc_c;
    logic             dec_c;

    // Hazard evaluation; a same-cycle writeback already resolves its register.
    always_comb begin
        wbclr_c = '0;
        if (sb.wb_valid && (sb.wb_rd != '0)) begin
            wbclr_c = NREG'(1) << sb.wb_rd;
        end
        epend_c = pending_q & ~wbclr_c;
        full_c  = (outstanding_q == CNT_W'(MAX_OUTSTANDING)) && !sb.wb_valid;
        ready_c = !((sb.issue_use_rs1 && epend_c[sb.issue_rs1]) ||
                    (sb.issue_use_rs2 && epend_c[sb.issue_rs2]) ||
                    ((sb.issue_rd != '0) && epend_c[sb.issue_rd]) ||
                    (sb.issue_long && full_c));
    end

    // Next-state: set beats clear for the same register, x0 never tracked.
    always_comb begin
        fire_c = sb.issue_valid && ready_c;
        inc_c  = fire_c && sb.issue_long;
        dec_c  = sb.wb_valid && (outstanding_q != '0);
        set_c  = '0;
        if (inc_c && (sb.issue_rd != '0)) begin
            set_c = NREG'(1) << sb.issue_rd;
        end
        pending_d     = (pending_q & ~wbclr_c) | set_c;
        pending_d[0]  = 1'b0;
        outstanding_d = outstanding_q + CNT_W'(inc_c) - CNT_W'(dec_c);
        error_d       = error_q ||
                        (sb.wb_valid && (outstanding_q == '0)) ||
                        (sb.wb_valid && (sb.wb_rd != '0) && !pending_q[sb.wb_rd]);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
        end
    end

    assign sb.issue_ready = ready_c;
    assign sb.pending     = pending_q;
    assign sb.outstanding = outstanding_q;
    assign sb.error       = error_q;
endmodule

// File: tb/tb_yarvi_scoreboard.sv
// Bench for yarvi_scoreboard: directed scenarios plus random traffic against a
// per-register reference model; a monitor pops expected records each cycle.
module tb_yarvi_scoreboard;
    localparam int unsigned MAXO = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    yarvi_scoreboard_if sb ();

    yarvi_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          chk_ready;
        bit          ready;
        bit          chk_state;
        logic [31:0] pend;
        logic [3:0]  outs;
        bit          err;
        int          step_no;
    } exp_t;

    exp_t expq[$];
    bit   m_pend[32];
    int   m_outs;
    bit   m_err;
    int   inflight[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_no = 0;

    // A register blocks issue if it is tracked and not being written back now.
    function automatic bit held(input int r, input bit wv, input int wrd);
        return (r != 0) && m_pend[r] && !(wv && (wrd == r));
    endfunction

    function automatic bit model_ready(input bit u1, input int r1, input bit u2, input int r2,
                                       input int rd, input bit lng, input bit wv, input int wrd);
        if (u1 && held(r1, wv, wrd)) return 1'b0;
        if (u2 && held(r2, wv, wrd)) return 1'b0;
        if ((rd != 0) && held(rd, wv, wrd)) return 1'b0;
        if (lng && (m_outs == int'(MAXO)) && !wv) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_outs = 0;
        m_err  = 1'b0;
        inflight.delete();
    endtask

    // One cycle: drive inputs, record what the DUT must show, advance the model.
    task automatic step(input bit rst, input bit v, input bit u1, input int r1,
                        input bit u2, input int r2, input int rd, input bit lng,
                        input bit wv, input int wrd, input bit chk_state);
        exp_t        e;
        bit          rdy;
        bit          fire;
        int          old_outs;
        logic [31:0] pv;
        @(negedge clock);
        #1;
        reset            = rst;
        sb.issue_valid   = v;
        sb.issue_use_rs1 = u1;
        sb.issue_rs1     = 5'(r1);
        sb.issue_use_rs2 = u2;
        sb.issue_rs2     = 5'(r2);
        sb.issue_rd      = 5'(rd);
        sb.issue_long    = lng;
        sb.wb_valid      = wv;
        sb.wb_rd         = 5'(wrd);
        rdy = model_ready(u1, r1, u2, r2, rd, lng, wv, wrd);
        for (int i = 0; i < 32; i++) pv[i] = m_pend[i];
        e.chk_ready = v && !rst;
        e.ready     = rdy;
        e.chk_state = chk_state;
        e.pend      = pv;
        e.outs      = 4'(m_outs);
        e.err       = m_err;
        e.step_no   = step_no;
        expq.push_back(e);
        step_no++;
        if (rst) begin
            model_clear();
        end else begin
            fire     = v && rdy;
            old_outs = m_outs;
            if (wv) begin
                if (old_outs == 0) m_err = 1'b1;
                if ((wrd != 0) && !m_pend[wrd]) m_err = 1'b1;
                if (wrd != 0) m_pend[wrd] = 1'b0;
                for (int i = 0; i < inflight.size(); i++) begin
                    if (inflight[i] == wrd) begin
                        inflight.delete(i);
                        break;
                    end
                end
            end
            if (fire && lng) begin
                if (rd != 0) m_pend[rd] = 1'b1;
                inflight.push_back(rd);
                m_outs++;
            end
            if (wv && (old_outs != 0)) m_outs--;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic rst_cycle();
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    endtask

    task automatic long_op(input int rd, input bit wv, input int wrd);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, rd, 1'b1, wv, wrd, 1'b1);
    endtask

    task automatic wb_only(input int wrd);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1, wrd, 1'b1);
    endtask

    // Monitor: compare DUT outputs against the oldest expected record.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                if (e.chk_ready) begin
                    checks++;
                    if (sb.issue_ready !== e.ready) begin
                        errors++;
                        $display("FAIL issue_ready step %0d got %b exp %b", e.step_no, sb.issue_ready, e.ready);
                    end
                end
                if (e.chk_state) begin
                    checks++;
                    if (sb.pending !== e.pend) begin
                        errors++;
                        $display("FAIL pending step %0d got %h exp %h", e.step_no, sb.pending, e.pend);
                    end
                    checks++;
                    if (sb.outstanding !== e.outs) begin
                        errors++;
                        $display("FAIL outstanding step %0d got %0d exp %0d", e.step_no, sb.outstanding, e.outs);
                    end
                    checks++;
                    if (sb.error !== e.err) begin
                        errors++;
                        $display("FAIL error step %0d got %b exp %b", e.step_no, sb.error, e.err);
                    end
                end
            end
        end
    end

    initial begin
        int rd, r1, r2, wrd;
        bit v, u1, u2, lng, wv;
        sb.issue_valid   = 1'b0;
        sb.issue_use_rs1 = 1'b0;
        sb.issue_use_rs2 = 1'b0;
        sb.issue_rs1     = '0;
        sb.issue_rs2     = '0;
        sb.issue_rd      = '0;
        sb.issue_long    = 1'b0;
        sb.wb_valid      = 1'b0;
        sb.wb_rd         = '0;
        model_clear();

        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        rst_cycle();

        // Load x5, dependent ADD stalls, issues in the writeback cycle.
        long_op(5, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 5, 1'b0, 0, 10, 1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 5, 1'b0, 0, 10, 1'b0, 1'b1, 5, 1'b1);
        idle();

        // Same-cycle writeback of x7 and a new long load to x7.
        long_op(7, 1'b0, 0);
        idle();
        long_op(7, 1'b1, 7);
        idle();
        wb_only(7);
        idle();

        // Capacity: four loads fill the tracker, a fifth needs a writeback.
        for (int i = 1; i <= 4; i++) long_op(i, 1'b0, 0);
        long_op(6, 1'b0, 0);
        long_op(6, 1'b1, 2);
        idle();
        wb_only(1);
        wb_only(3);
        wb_only(4);
        wb_only(6);
        idle();

        // WAW stall, unused rs1 not stalling, long op to x0.
        long_op(3, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 3, 1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 3, 1'b0, 0, 8, 1'b0, 1'b0, 0, 1'b1);
        long_op(0, 1'b0, 0);
        idle();
        wb_only(3);
        wb_only(0);
        idle();

        // Protocol errors: writeback with nothing outstanding, stale register.
        wb_only(0);
        idle();
        idle();
        rst_cycle();
        idle();
        long_op(1, 1'b0, 0);
        wb_only(9);
        idle();
        rst_cycle();

        // Reset with three loads in flight; dependent op issues right away.
        long_op(11, 1'b0, 0);
        long_op(12, 1'b0, 0);
        long_op(13, 1'b0, 0);
        rst_cycle();
        step(1'b0, 1'b1, 1'b1, 11, 1'b1, 12, 13, 1'b0, 1'b0, 0, 1'b1);
        idle();

        // Random traffic with legal writebacks of in-flight ops.
        for (int n = 0; n < 1500; n++) begin
            v   = ($urandom_range(0, 99) < 75);
            r1  = $urandom_range(0, 7);
            r2  = $urandom_range(0, 7);
            rd  = $urandom_range(0, 7);
            u1  = (r1 != 0) && ($urandom_range(0, 1) == 1);
            u2  = (r2 != 0) && ($urandom_range(0, 1) == 1);
            lng = ($urandom_range(0, 99) < 40);
            wv  = 1'b0;
            wrd = 0;
            if ((inflight.size() > 0) && ($urandom_range(0, 99) < 40)) begin
                wv  = 1'b1;
                wrd = inflight[$urandom_range(0, inflight.size() - 1)];
            end
            step(1'b0, v, u1, r1, u2, r2, rd, lng, wv, wrd, 1'b1);
        end
        while (inflight.size() > 0) wb_only(inflight[0]);
        idle();

        @(negedge clock);
        #3;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0 pending records", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
